arm_multicycle_mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle ARM core: the other end of the controller's memory request interface (fetch, load, store).
- Accepts one request at a time on a valid/ready request channel and inserts a configurable number of wait states.
- Performs a word-aligned, byte-enabled read or write on an internal single-port RAM, then returns a response on a valid/ready response channel.
- Sits between the datapath address/write-data muxes and the unified instruction/data storage.

---
 rtl/arm_multicycle_mem_responder_pkg.sv | 24 ++
 rtl/arm_multicycle_mem_responder_if.sv | 26 ++
 rtl/arm_multicycle_mem_responder_array.sv | 27 ++
 rtl/arm_multicycle_mem_responder.sv | 101 ++++++++++
 tb/tb_arm_multicycle_mem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/arm_multicycle_mem_responder_pkg.sv
// Shared types and helpers for the multi-cycle ARM memory responder.
package arm_multicycle_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int BUS_WIDTH_DFLT = 32;
  localparam int BYTES_PER_WORD = BUS_WIDTH_DFLT / 8;

  // Misaligned, or any bit above the RAM's byte-address range is set.
  function automatic logic addr_err(input logic [63:0] addr, input int bus_w, input int addr_w);
    logic e;
    e = |addr[1:0];
    for (int i = 2; i < 64; i++) begin
      if (i >= addr_w + 2 && i < bus_w) e = e | addr[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/arm_multicycle_mem_responder_if.sv
// Request/response channel between the core's memory controller and the responder.
interface arm_multicycle_mem_responder_if #(
  parameter int BusWidth = 32
);
  logic                  Req_Valid;
  logic                  Req_Ready;
  logic [BusWidth-1:0]   Req_Addr;
  logic                  Req_Write;
  logic [BusWidth-1:0]   Req_WData;
  logic [BusWidth/8-1:0] Req_ByteEn;
  logic                  Resp_Valid;
  logic                  Resp_Ready;
  logic [BusWidth-1:0]   Resp_RData;
  logic                  Resp_Err;
  logic                  Busy;

  modport slave (
    input  Req_Valid, Req_Addr, Req_Write, Req_WData, Req_ByteEn, Resp_Ready,
    output Req_Ready, Resp_Valid, Resp_RData, Resp_Err, Busy
  );

  modport master (
    output Req_Valid, Req_Addr, Req_Write, Req_WData, Req_ByteEn, Resp_Ready,
    input  Req_Ready, Resp_Valid, Resp_RData, Resp_Err, Busy
  );
endinterface

// File: rtl/arm_multicycle_mem_responder_array.sv
// Single-port synchronous RAM with byte-lane writes; contents are never reset.
module arm_multicycle_mem_array #(
  parameter int BusWidth  = 32,
  parameter int AddrWidth = 10
) (
  input  logic                  i_CLK,
  input  logic                  i_En,
  input  logic                  i_WE,
  input  logic [BusWidth/8-1:0] i_ByteEn,
  input  logic [AddrWidth-1:0]  i_Addr,
  input  logic [BusWidth-1:0]   i_WData,
  output logic [BusWidth-1:0]   o_RData
);
  logic [BusWidth-1:0] mem_q [2**AddrWidth];

  always_ff @(posedge i_CLK) begin
    if (i_En) begin
      if (i_WE) begin
        for (int b = 0; b < BusWidth / 8; b++) begin
          if (i_ByteEn[b]) mem_q[i_Addr][b*8 +: 8] <= i_WData[b*8 +: 8];
        end
      end else begin
        o_RData <= mem_q[i_Addr];
      end
    end
  end
endmodule

// File: rtl/arm_multicycle_mem_responder.sv
// Memory-side responder: accepts one request, waits WaitStates cycles, accesses the RAM, responds.
module arm_multicycle_mem_responder
  import arm_multicycle_mem_pkg::*;
#(
  parameter int BusWidth   = BUS_WIDTH_DFLT,
  parameter int AddrWidth  = 10,
  parameter int WaitStates = 2
) (
  input  logic                           i_CLK,
  input  logic                           i_NRESET,
  arm_multicycle_mem_responder_if.slave  mem_bus
);
  localparam int Lanes = BusWidth / 8;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BusWidth-1:0] addr_q, wdata_q;
  logic                write_q;
  logic [Lanes-1:0]    be_q;
  logic                accept, err, arr_en;
  logic [BusWidth-1:0] arr_rdata;

  assign accept = (state_q == ST_IDLE) && mem_bus.Req_Valid;
  assign err    = addr_err(64'(addr_q), BusWidth, AddrWidth);

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mem_bus.Req_Addr;
        wdata_q <= mem_bus.Req_WData;
        write_q <= mem_bus.Req_Write;
        be_q    <= mem_bus.Req_ByteEn;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = 4'(WaitStates);
          state_d = (WaitStates > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (mem_bus.Resp_Ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Read data is taken straight from the RAM register: it only changes on an enabled access.
  always_comb begin
    mem_bus.Req_Ready  = 1'b0;
    mem_bus.Resp_Valid = 1'b0;
    mem_bus.Resp_RData = '0;
    mem_bus.Resp_Err   = 1'b0;
    mem_bus.Busy       = 1'b1;
    arr_en             = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_bus.Req_Ready = 1'b1;
        mem_bus.Busy      = 1'b0;
      end
      ST_ACCESS: arr_en = !err;
      ST_RESP: begin
        mem_bus.Resp_Valid = 1'b1;
        mem_bus.Resp_Err   = err;
        mem_bus.Resp_RData = (err || write_q) ? '0 : arr_rdata;
      end
      default: ;
    endcase
  end

  arm_multicycle_mem_array #(
    .BusWidth  (BusWidth),
    .AddrWidth (AddrWidth)
  ) u_array (
    .i_CLK    (i_CLK),
    .i_En     (arr_en),
    .i_WE     (write_q),
    .i_ByteEn (be_q),
    .i_Addr   (addr_q[AddrWidth+1:2]),
    .i_WData  (wdata_q),
    .o_RData  (arr_rdata)
  );
endmodule

// File: tb/tb_arm_multicycle_mem_responder.sv
// Scoreboard bench for the memory responder: randomized traffic against a word-array reference model.
module tb_arm_multicycle_mem_responder;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  arm_multicycle_mem_responder_if #(.BusWidth(32)) bus ();
  arm_multicycle_mem_responder_if #(.BusWidth(32)) bus0 ();

  arm_multicycle_mem_responder #(.BusWidth(32), .AddrWidth(10), .WaitStates(WS)) dut (
    .i_CLK(clk), .i_NRESET(rst_n), .mem_bus(bus)
  );
  arm_multicycle_mem_responder #(.BusWidth(32), .AddrWidth(10), .WaitStates(0)) dut0 (
    .i_CLK(clk), .i_NRESET(rst_n), .mem_bus(bus0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model[int];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  bit          rr_hold  = 1'b0;
  bit          mon_en   = 1'b0;
  bit          prev_v   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model.exists(int'(a >> 2)) ? model[int'(a >> 2)] : 32'h0;
  endfunction

  // Reference: 1024 words of 4 bytes, byte address must be word aligned and below 4096.
  task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] be, input bit track);
    int          g;
    int unsigned c_acc;
    exp_t        e;
    logic [31:0] w;
    @(posedge clk); #1;
    bus.Req_Valid = 1'b1; bus.Req_Addr = a; bus.Req_Write = wr;
    bus.Req_WData = wd;   bus.Req_ByteEn = be;
    g = 0;
    @(negedge clk);
    while (!bus.Req_Ready && g < 60) begin @(negedge clk); g++; end
    if (!bus.Req_Ready) begin
      chk("req_accept_timeout", 64'd0, 64'd1);
      bus.Req_Valid = 1'b0;
      return;
    end
    c_acc = cyc + 1;
    @(posedge clk); #1;
    bus.Req_Valid = 1'b0; bus.Req_Addr = $urandom; bus.Req_Write = 1'($urandom);
    bus.Req_WData = $urandom; bus.Req_ByteEn = 4'($urandom);
    if (track) begin
      e.acc   = c_acc;
      e.err   = (a % 4 != 0) || (a >= 32'd4096);
      e.rdata = 32'h0;
      if (!e.err && wr) begin
        w = model_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        model[int'(a >> 2)] = w;
      end else if (!e.err) begin
        e.rdata = model_rd(a);
      end
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() > 0 && g < 300) begin @(negedge clk); g++; end
    if (sbq.size() > 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic t0(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                    input logic [3:0] be, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    bus0.Req_Valid = 1'b1; bus0.Req_Addr = a; bus0.Req_Write = wr;
    bus0.Req_WData = wd;   bus0.Req_ByteEn = be;
    @(negedge clk);
    chk("ws0_req_ready", 64'(bus0.Req_Ready), 64'd1);
    @(posedge clk); #1;
    bus0.Req_Valid = 1'b0;
    @(negedge clk);
    chk("ws0_valid_early", 64'(bus0.Resp_Valid), 64'd0);
    @(negedge clk);
    chk("ws0_valid", 64'(bus0.Resp_Valid), 64'd1);
    chk("ws0_rdata", 64'(bus0.Resp_RData), 64'(exp_rd));
    chk("ws0_err", 64'(bus0.Resp_Err), 64'd0);
  endtask

  always @(posedge clk) begin
    #2;
    bus.Resp_Ready = rr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every response cycle against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.Resp_Valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          if (!prev_v) chk("resp_latency", 64'(cyc), 64'(sbq[0].acc + WS + 1));
          chk("resp_rdata", 64'(bus.Resp_RData), 64'(sbq[0].rdata));
          chk("resp_err", 64'(bus.Resp_Err), 64'(sbq[0].err));
          chk("resp_req_ready_low", 64'(bus.Req_Ready), 64'd0);
          chk("resp_busy", 64'(bus.Busy), 64'd1);
          if (bus.Resp_Ready) void'(sbq.pop_front());
        end
      end else begin
        chk("idle_resp_clear", {31'd0, bus.Resp_Err, bus.Resp_RData}, 64'd0);
      end
      prev_v = bus.Resp_Valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int          g;
    bus.Req_Valid = 1'b0; bus.Req_Addr = '0; bus.Req_Write = 1'b0;
    bus.Req_WData = '0;   bus.Req_ByteEn = '0; bus.Resp_Ready = 1'b1;
    bus0.Req_Valid = 1'b0; bus0.Req_Addr = '0; bus0.Req_Write = 1'b0;
    bus0.Req_WData = '0;   bus0.Req_ByteEn = '0; bus0.Resp_Ready = 1'b1;
    #2;
    chk("rst_req_ready", 64'(bus.Req_Ready), 64'd1);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_valid", 64'(bus.Resp_Valid), 64'd0);
    chk("rst_out", {31'd0, bus.Resp_Err, bus.Resp_RData}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    t0(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0);
    t0(32'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF);

    mon_en = 1'b1;
    for (int w = 0; w < 16; w++) issue(32'(w * 4), 1'b1, $urandom, 4'hF, 1'b1);

    issue(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(32'h10, 1'b0, 32'h0, 4'h0, 1'b1);
    issue(32'h10, 1'b1, 32'h0000AA00, 4'b0010, 1'b1);
    issue(32'h10, 1'b0, 32'h0, 4'h0, 1'b1);
    issue(32'h13, 1'b0, 32'h0, 4'h0, 1'b1);
    issue(32'h00001000, 1'b0, 32'h0, 4'h0, 1'b1);
    issue(32'h11, 1'b1, 32'h11223344, 4'hF, 1'b1);
    issue(32'h10, 1'b1, 32'h55667788, 4'h0, 1'b1);
    issue(32'h10, 1'b0, 32'h0, 4'h0, 1'b1);
    drain();

    rr_hold = 1'b1;
    issue(32'h10, 1'b0, 32'h0, 4'h0, 1'b1);
    g = 0;
    while (!bus.Resp_Valid && g < 20) begin @(negedge clk); g++; end
    chk("bp_valid_seen", 64'(bus.Resp_Valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.Req_Valid = 1'b1; bus.Req_Addr = 32'h8; bus.Req_Write = 1'b1; bus.Req_ByteEn = 4'hF;
      @(negedge clk);
      chk("bp_req_ready", 64'(bus.Req_Ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.Req_Valid = 1'b0;
    rr_hold = 1'b0;
    drain();

    issue(32'h20, 1'b1, 32'h12345678, 4'hF, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wait_req_ready", 64'(bus.Req_Ready), 64'd1);
    chk("rst_wait_busy", 64'(bus.Busy), 64'd0);
    chk("rst_wait_valid", 64'(bus.Resp_Valid), 64'd0);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    issue(32'h20, 1'b0, 32'h0, 4'h0, 1'b1);
    drain();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 63));
        1:       a = $urandom | 32'h1000;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      issue(a, 1'($urandom), $urandom, 4'($urandom), 1'b1);
    end
    drain();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
